prog_loader: RTL and testbench

Boot-time program loader for the single-cycle CPU. It accepts a framed byte stream from a host link, packs the bytes into big-endian 32-bit words, and writes them into the unified instruction/data memory through its write port. While loading, it holds the CPU in reset, and it releases the CPU only after the checksum verifies. It is the writer side of the instruction-fetch path: it fills the memory the CPU later reads from PC=BASE_ADDR.

---
 rtl/prog_loader_pkg.sv | 30 +++
 rtl/prog_loader_if.sv | 17 +
 rtl/prog_loader_word_packer.sv | 41 ++++
 rtl/prog_loader.sv | 163 ++++++++++++++++
 tb/tb_prog_loader.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: field widths,
// the frame sync byte, FSM state encoding and word address arithmetic.
package prog_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;
  localparam int CHK_W  = 8;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Byte address of word idx; the sum wraps modulo 2^32.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  idx);
    return base + {{(ADDR_W-LEN_W-2){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Host byte stream plus memory write port of the program loader.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_din;

  modport master (output in_data, in_valid,
                  input  in_ready, mem_we, mem_addr, mem_din);

  modport slave  (input  in_data, in_valid,
                  output in_ready, mem_we, mem_addr, mem_din);
endinterface

// File: rtl/prog_loader_word_packer.sv
// Packs bytes MSB-first into 32-bit words; word_full flags the push that
// completes a word, with word already including that byte.
module word_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_full,
  output logic [WORD_W-1:0] word
);

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] sr_q, sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clear) begin
      cnt_d = '0;
    end else if (push) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {sr_q[WORD_W-BYTE_W-1:0], byte_in};
    end
  end

  assign word      = {sr_q[WORD_W-BYTE_W-1:0], byte_in};
  assign word_full = push && (cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives A5/LEN/payload/CHK frames, writes big-endian words
// to memory and keeps the CPU in reset until a frame checksum verifies.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
)(
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.slave      bus,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  words_loaded
);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CHK_W-1:0]  chk_q, chk_d;
  logic [LEN_W-1:0]  wl_q, wl_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_din_q, mem_din_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic              restart;
  logic [LEN_W-1:0]  len_full;
  logic              pk_clear, pk_push, pk_full;
  logic [WORD_W-1:0] pk_word;

  assign bus.in_ready = (state_q != ST_WRITE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign len_full     = {len_q[LEN_W-1:BYTE_W], bus.in_data};

  word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .push      (pk_push),
    .byte_in   (bus.in_data),
    .word_full (pk_full),
    .word      (pk_word)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    chk_d       = chk_q;
    wl_d        = wl_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;
    pk_clear    = 1'b0;
    pk_push     = 1'b0;
    restart     = 1'b0;

    case (state_q)
      ST_SYNC, ST_DONE, ST_ERROR: begin
        if (accept && (bus.in_data == SYNC_BYTE)) begin
          restart = 1'b1;
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d[LEN_W-1:BYTE_W] = bus.in_data;
          state_d               = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          if ({16'd0, len_full} > MAX_WORDS) state_d = ST_ERROR;
          else if (len_full == '0)           state_d = ST_CHECK;
          else                               state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          pk_push = 1'b1;
          chk_d   = chk_q ^ bus.in_data;
          // Write strobe and payload are registered on the word's last byte.
          if (pk_full) begin
            state_d    = ST_WRITE;
            mem_we_d   = 1'b1;
            mem_addr_d = word_addr(BASE_ADDR, wl_q);
            mem_din_d  = pk_word;
          end
        end
      end
      ST_WRITE: begin
        if (wl_q < len_q) wl_d = wl_q + 16'd1;
        if (({1'b0, wl_q} + 17'd1) < {1'b0, len_q}) state_d = ST_DATA;
        else                                         state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (accept) state_d = (bus.in_data == chk_q) ? ST_DONE : ST_ERROR;
      end
      default: state_d = ST_SYNC;
    endcase

    // Status follows the state register one edge later, so release is glitch-free.
    if (restart) begin
      pk_clear    = 1'b1;
      chk_d       = '0;
      wl_d        = '0;
      cpu_reset_d = 1'b1;
      done_d      = 1'b0;
      error_d     = 1'b0;
    end else if (state_q == ST_DONE) begin
      cpu_reset_d = 1'b0;
      done_d      = 1'b1;
      error_d     = 1'b0;
    end else if (state_q == ST_ERROR) begin
      cpu_reset_d = 1'b1;
      done_d      = 1'b0;
      error_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SYNC;
      wl_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_din_q   <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wl_q        <= wl_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    len_q <= len_d;
    chk_q <= chk_d;
  end

  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign cpu_reset    = cpu_reset_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized frame bench for prog_loader with a frame-level reference model
// (expected writes and final status derived from the payload list).
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_reset, done, error;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  prog_loader_if bus();

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  int          ready_bad = 0;
  logic [63:0] wr_q[$];
  logic [7:0]  pay_q[$];

  // Record every write cycle and any cycle where in_ready is not the inverse of mem_we.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.in_ready === bus.mem_we) ready_bad++;
      if (bus.mem_we === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_din});
    end
  end

  // Entered and left just after a rising edge; leaves just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL send_timeout in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic fill_pay(input int nwords);
    pay_q.delete();
    for (int i = 0; i < nwords * 4; i++) pay_q.push_back(8'($urandom));
  endtask

  task automatic run_frame(input string name, input int len, input bit force_chk,
                           input logic [7:0] chk_val, input bit gaps);
    logic [7:0]  ck;
    logic [7:0]  chk_byte;
    logic [15:0] l16;
    logic [31:0] w;
    logic [63:0] exp_wr;
    bit          len_ok, ok;
    int          ws, bs, nexp, ngot;
    ck = 8'h00;
    for (int i = 0; i < pay_q.size(); i++) ck ^= pay_q[i];
    chk_byte = force_chk ? chk_val : ck;
    len_ok   = (len <= MAXW);
    ok       = len_ok && (chk_byte == ck);
    nexp     = len_ok ? len : 0;
    l16      = 16'(len);
    ws       = wr_q.size();
    bs       = ready_bad;

    send_byte(8'hA5, gaps);
    send_byte(l16[15:8], gaps);
    send_byte(l16[7:0], gaps);
    if (len_ok) begin
      for (int i = 0; i < len * 4; i++) send_byte(pay_q[i], gaps);
      send_byte(chk_byte, gaps);
    end

    checks++;
    if (done !== 1'b0 || error !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL %s_early done=%b error=%b cpu_reset=%b required 0 0 1", name, done, error, cpu_reset);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== ok) begin
      errors++;
      $display("FAIL %s_done got %b required %b", name, done, ok);
    end
    checks++;
    if (error !== !ok) begin
      errors++;
      $display("FAIL %s_error got %b required %b", name, error, !ok);
    end
    checks++;
    if (cpu_reset !== !ok) begin
      errors++;
      $display("FAIL %s_cpu_reset got %b required %b", name, cpu_reset, !ok);
    end
    checks++;
    if (words_loaded !== 16'(nexp)) begin
      errors++;
      $display("FAIL %s_words_loaded got %0d required %0d", name, words_loaded, nexp);
    end

    repeat (2) begin @(posedge clk); #1; end
    ngot = wr_q.size() - ws;
    checks++;
    if (ngot !== nexp) begin
      errors++;
      $display("FAIL %s_write_count got %0d required %0d", name, ngot, nexp);
    end
    for (int i = 0; i < nexp && i < ngot; i++) begin
      w = {pay_q[4*i], pay_q[4*i+1], pay_q[4*i+2], pay_q[4*i+3]};
      exp_wr = {BASE + 32'(i * 4), w};
      checks++;
      if (wr_q[ws+i] !== exp_wr) begin
        errors++;
        $display("FAIL %s_write%0d got addr=%h data=%h required addr=%h data=%h",
                 name, i, wr_q[ws+i][63:32], wr_q[ws+i][31:0], exp_wr[63:32], exp_wr[31:0]);
      end
    end
    checks++;
    if (ready_bad - bs !== 0) begin
      errors++;
      $display("FAIL %s_in_ready got %0d bad cycles required 0", name, ready_bad - bs);
    end
  endtask

  task automatic set_basic_pay();
    pay_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake in_ready=%b mem_we=%b required 1 0", bus.in_ready, bus.mem_we);
    end
    checks++;
    if (bus.mem_addr !== BASE || bus.mem_din !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem addr=%h din=%h required %h 00000000", bus.mem_addr, bus.mem_din, BASE);
    end
    checks++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || words_loaded !== 16'd0) begin
      errors++;
      $display("FAIL reset_status cpu_reset=%b done=%b error=%b words=%0d required 1 0 0 0",
               cpu_reset, done, error, words_loaded);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_garbage();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    pay_q.delete();
    run_frame("garbage", 0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_basic();
    int ws;
    ws = wr_q.size();
    set_basic_pay();
    run_frame("basic", 2, 1'b1, 8'h25, 1'b0);
    checks++;
    if (wr_q.size() < ws + 2 || wr_q[ws] !== 64'h00000000_20080005 || wr_q[ws+1] !== 64'h00000004_00000008) begin
      errors++;
      $display("FAIL basic_literal_words writes=%0d required 2 at 0x0/0x4", wr_q.size() - ws);
    end
  endtask

  task automatic test_bad_chk();
    set_basic_pay();
    run_frame("bad_chk", 2, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_len_error();
    pay_q.delete();
    run_frame("len_over", MAXW + 1, 1'b0, 8'h00, 1'b0);
    fill_pay(3);
    run_frame("after_len_over", 3, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_len_max();
    fill_pay(MAXW);
    run_frame("len_max", MAXW, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    fill_pay(2);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(pay_q[i], 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (bus.mem_we !== 1'b0 || cpu_reset !== 1'b1 || words_loaded !== 16'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid mem_we=%b cpu_reset=%b words=%0d in_ready=%b required 0 1 0 1",
               bus.mem_we, cpu_reset, words_loaded, bus.in_ready);
    end
    fill_pay(2);
    run_frame("restart", 2, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_gaps();
    set_basic_pay();
    run_frame("gaps_basic", 2, 1'b1, 8'h25, 1'b1);
    fill_pay(5);
    run_frame("gaps_rand", 5, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    int len;
    for (int n = 0; n < 12; n++) begin
      len = $urandom_range(0, MAXW + 2);
      fill_pay((len <= MAXW) ? len : 0);
      run_frame("random", len, ($urandom_range(0, 2) == 0), 8'($urandom), $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_garbage();
    test_basic();
    test_bad_chk();
    test_len_error();
    test_len_max();
    test_reset_mid();
    test_gaps();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
